dcache_port_responder: RTL and testbench

- Memory-side responder for one D$ request port (dcache_req_i_t in, dcache_req_o_t out), backed by an internal word-addressed scratchpad.
- Grants store and load requests from the store buffer and load unit.
- Performs byte-enabled writes and returns load data after a fixed latency.
- Used as a cache stand-in for unit-level LSU integration and as a deterministic memory in block benches.

---
 rtl/dcache_port_responder.sv | 212 +++++++++++++++++++++
 tb/tb_dcache_port_responder.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_port_responder.sv
// dcache_port_responder: scratchpad-backed responder for a single D$ request port.
// Stores are granted and written in one cycle. A load is granted with its index,
// then waits in TAG for the tag (or a kill). Read data comes back through a fixed
// latency pipe.

package dcache_port_pkg;

  typedef enum logic [3:0] {
    AMO_NONE = 4'h0,
    AMO_LR   = 4'h1,
    AMO_SC   = 4'h2,
    AMO_SWAP = 4'h3,
    AMO_ADD  = 4'h4,
    AMO_AND  = 4'h5,
    AMO_OR   = 4'h6,
    AMO_XOR  = 4'h7,
    AMO_MAX  = 4'h8,
    AMO_MAXU = 4'h9,
    AMO_MIN  = 4'hA,
    AMO_MINU = 4'hB,
    AMO_CAS1 = 4'hC,
    AMO_CAS2 = 4'hD
  } amo_t;

  typedef struct packed {
    logic [11:0] address_index;
    logic [43:0] address_tag;
    logic [63:0] data_wdata;
    logic        data_req;
    logic        data_we;
    logic [7:0]  data_be;
    logic [1:0]  data_size;
    amo_t        amo_op;
    logic        kill_req;
    logic        tag_valid;
  } dcache_req_i_t;

  typedef struct packed {
    logic        data_gnt;
    logic        data_rvalid;
    logic [63:0] data_rdata;
  } dcache_req_o_t;

endpackage

module dcache_port_responder
  import dcache_port_pkg::*;
#(
  parameter int unsigned NUM_WORDS  = 1024,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned GNT_DELAY  = 0
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  dcache_req_i_t req_port_i,
  output dcache_req_o_t req_port_o
);

  localparam int unsigned IDX_W = $clog2(NUM_WORDS);

  typedef enum logic {
    IDLE,
    TAG
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       wait_cnt_q, wait_cnt_d;
  logic [11:0]      index_q, index_d;
  logic             gnt;
  logic             store_en;
  logic             push;
  logic [55:0]      req_addr;
  logic [55:0]      tag_addr;
  logic [IDX_W-1:0] store_word;
  logic [IDX_W-1:0] tag_word;

  logic [63:0]      mem [NUM_WORDS];

  logic [RD_LATENCY-1:0] pipe_valid_q;
  logic [63:0]           pipe_data_q [RD_LATENCY];

  // Upper address bits and the size field are deliberately ignored; gathering
  // them here keeps that choice visible in one place.
  logic unused_req_bits;
  assign unused_req_bits = ^req_port_i;

  // Stores use the full address presented with the request. Loads combine the
  // index latched at grant with the tag presented in the tag cycle.
  assign req_addr   = {req_port_i.address_tag, req_port_i.address_index};
  assign tag_addr   = {req_port_i.address_tag, index_q};
  assign store_word = req_addr[3 +: IDX_W];
  assign tag_word   = tag_addr[3 +: IDX_W];

  // State register for the grant/tag handshake and the grant-delay counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      index_q    <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      index_q    <= index_d;
    end
  end

  // Next-state logic: grant after GNT_DELAY held cycles, then handle tag or kill.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    index_d    = index_q;
    gnt        = 1'b0;
    store_en   = 1'b0;
    push       = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_port_i.data_req) begin
          if (wait_cnt_q == 4'(GNT_DELAY)) begin
            gnt        = 1'b1;
            wait_cnt_d = '0;
            if (req_port_i.data_we) begin
              store_en = 1'b1;
            end else begin
              index_d = req_port_i.address_index;
              state_d = TAG;
            end
          end else begin
            wait_cnt_d = wait_cnt_q + 4'd1;
          end
        end else begin
          wait_cnt_d = '0;
        end
      end
      TAG: begin
        wait_cnt_d = '0;
        if (req_port_i.kill_req) begin
          state_d = IDLE;
        end else if (req_port_i.tag_valid) begin
          push    = 1'b1;
          state_d = IDLE;
        end
      end
    endcase
    if (rst_i) begin
      gnt      = 1'b0;
      store_en = 1'b0;
      push     = 1'b0;
    end
  end

  // Byte-enabled scratchpad write; contents survive reset on purpose.
  always_ff @(posedge clk_i) begin
    if (store_en) begin
      for (int b = 0; b < 8; b++) begin
        if (req_port_i.data_be[b]) begin
          mem[store_word][8*b +: 8] <= req_port_i.data_wdata[8*b +: 8];
        end
      end
    end
  end

  // Latency pipe: the word read in the tag cycle shifts through RD_LATENCY stages.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pipe_valid_q <= '0;
      for (int i = 0; i < int'(RD_LATENCY); i++) begin
        pipe_data_q[i] <= '0;
      end
    end else begin
      pipe_valid_q[0] <= push;
      pipe_data_q[0]  <= push ? mem[tag_word] : 64'd0;
      for (int i = 1; i < int'(RD_LATENCY); i++) begin
        pipe_valid_q[i] <= pipe_valid_q[i-1];
        pipe_data_q[i]  <= pipe_data_q[i-1];
      end
    end
  end

  assign req_port_o.data_gnt    = gnt;
  assign req_port_o.data_rvalid = pipe_valid_q[RD_LATENCY-1] && !rst_i;
  assign req_port_o.data_rdata  = req_port_o.data_rvalid ? pipe_data_q[RD_LATENCY-1] : 64'd0;

`ifndef SYNTHESIS
  logic req_pending_q;

  // Remember whether a request was left waiting for grant in the previous cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      req_pending_q <= 1'b0;
    end else begin
      req_pending_q <= (state_q == IDLE) && req_port_i.data_req && !gnt;
    end
  end

  // Protocol checks on the requester side of the port.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (req_pending_q) begin
        assert (req_port_i.data_req)
          else $warning("dcache_port_responder: data_req withdrawn before data_gnt");
      end
      assert (!((state_q == IDLE) && req_port_i.tag_valid && req_port_i.kill_req))
        else $error("dcache_port_responder: tag_valid and kill_req together in IDLE");
      if (gnt) begin
        assert (req_port_i.amo_op == AMO_NONE)
          else $error("dcache_port_responder: amo_op other than AMO_NONE treated as plain access");
      end
    end
  end
`endif

endmodule

// File: tb/tb_dcache_port_responder.sv
// tb_dcache_port_responder: drives two responder instances (different depth,
// grant delay and read latency) with directed and random traffic and compares
// every cycle against a word-level memory model and an rvalid schedule.

module tb_dcache_port_responder;
  import dcache_port_pkg::*;

  localparam int NW0 = 1024;
  localparam int NW1 = 64;
  localparam int GD0 = 0;
  localparam int GD1 = 2;
  localparam int RL0 = 1;
  localparam int RL1 = 3;

  logic          clk = 1'b0;
  logic          rst;
  dcache_req_i_t req [2];
  dcache_req_o_t rsp [2];

  int assertCount = 0;
  int errCount    = 0;
  int cyc         = 0;

  // Reference state: memory per instance keyed by instance and word index,
  // words fully written at least once, and the cycle each rvalid is due.
  logic [63:0] modelMem [int];
  bit          known    [int];
  logic [63:0] expRv    [int];

  dcache_port_responder #(.NUM_WORDS(NW0), .RD_LATENCY(RL0), .GNT_DELAY(GD0)) dut0 (
    .clk_i      (clk),
    .rst_i      (rst),
    .req_port_i (req[0]),
    .req_port_o (rsp[0])
  );

  dcache_port_responder #(.NUM_WORDS(NW1), .RD_LATENCY(RL1), .GNT_DELAY(GD1)) dut1 (
    .clk_i      (clk),
    .rst_i      (rst),
    .req_port_i (req[1]),
    .req_port_o (rsp[1])
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int nw(input int s);
    return (s == 0) ? NW0 : NW1;
  endfunction

  function automatic int gntDelay(input int s);
    return (s == 0) ? GD0 : GD1;
  endfunction

  function automatic int rdLat(input int s);
    return (s == 0) ? RL0 : RL1;
  endfunction

  function automatic int mkey(input int s, input logic [55:0] a);
    longint unsigned addr;
    addr = longint'(a);
    return s * 4096 + int'((addr / 8) % longint'(nw(s)));
  endfunction

  // Random address that lands on word w of instance s, with random upper and byte bits.
  function automatic logic [55:0] mkAddr(input int s, input int w);
    longint unsigned r;
    longint unsigned span;
    r    = {$urandom, $urandom};
    r    = r % (longint'(1) << 56);
    span = 8 * longint'(nw(s));
    return 56'((r / span) * span + longint'(w) * 8 + (r % 8));
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      errCount++;
      $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
      $error("[TB] %s observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int s, input logic reqV, input logic we, input logic [55:0] addr,
                               input logic [63:0] data, input logic [7:0] be, input logic kill,
                               input logic tagv);
    req[s].address_index = addr[11:0];
    req[s].address_tag   = addr[55:12];
    req[s].data_wdata    = data;
    req[s].data_req      = reqV;
    req[s].data_we       = we;
    req[s].data_be       = be;
    req[s].data_size     = 2'($urandom);
    req[s].amo_op        = AMO_NONE;
    req[s].kill_req      = kill;
    req[s].tag_valid     = tagv;
  endtask

  task automatic idle(input int s);
    applyStimulus(s, 1'b0, 1'b0, 56'd0, 64'd0, 8'd0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold the current request until granted; the wait must equal the grant delay.
  task automatic waitGrant(input int s, output int waited);
    waited = 0;
    #1;
    while (!rsp[s].data_gnt && waited < 20) begin
      waited++;
      tick();
      #1;
    end
    checkOutput($sformatf("gnt_wait_d%0d", s), 64'(waited), 64'(gntDelay(s)));
  endtask

  task automatic doStore(input int s, input logic [55:0] addr, input logic [63:0] data,
                         input logic [7:0] be, output int gntCyc);
    int          waited;
    int          k;
    logic [63:0] w;
    applyStimulus(s, 1'b1, 1'b1, addr, data, be, 1'b0, 1'b0);
    waitGrant(s, waited);
    gntCyc = cyc;
    k = mkey(s, addr);
    w = modelMem.exists(k) ? modelMem[k] : 64'bx;
    for (int b = 0; b < 8; b++) begin
      if (be[b]) w[8*b +: 8] = data[8*b +: 8];
    end
    modelMem[k] = w;
    if (be == 8'hFF) known[k] = 1'b1;
    tick();
  endtask

  task automatic doLoad(input int s, input logic [55:0] addr, input bit kill, input int tagWait);
    int         waited;
    logic [55:0] junk;
    applyStimulus(s, 1'b1, 1'b0, addr, {$urandom, $urandom}, 8'($urandom), 1'b0, 1'b0);
    waitGrant(s, waited);
    tick();
    for (int i = 0; i < tagWait; i++) begin
      junk = {$urandom, $urandom};
      applyStimulus(s, 1'b1, 1'b1, junk, {$urandom, $urandom}, 8'($urandom), 1'b0, 1'b0);
      #1;
      checkOutput($sformatf("tag_wait_gnt_d%0d", s), 64'(rsp[s].data_gnt), 64'd0);
      tick();
    end
    junk = {addr[55:12], 12'($urandom)};
    applyStimulus(s, 1'b1, 1'b1, junk, {$urandom, $urandom}, 8'($urandom), kill,
                  kill ? 1'($urandom) : 1'b1);
    #1;
    checkOutput($sformatf("tag_gnt_d%0d", s), 64'(rsp[s].data_gnt), 64'd0);
    if (!kill) expRv[(cyc + rdLat(s)) * 2 + s] = modelMem[mkey(s, addr)];
    tick();
    idle(s);
  endtask

  // Every cycle, both instances must show exactly the scheduled rvalid/rdata.
  always @(negedge clk) begin
    if (rst) expRv.delete();
    for (int s = 0; s < 2; s++) begin
      logic        expV;
      logic [63:0] expD;
      int          key;
      key = cyc * 2 + s;
      expV = 1'b0;
      expD = 64'd0;
      if (expRv.exists(key)) begin
        expV = 1'b1;
        expD = expRv[key];
        expRv.delete(key);
      end
      checkOutput($sformatf("rvalid_d%0d_c%0d", s, cyc), 64'(rsp[s].data_rvalid), 64'(expV));
      checkOutput($sformatf("rdata_d%0d_c%0d", s, cyc), rsp[s].data_rdata, expD);
      if (rst) checkOutput($sformatf("reset_gnt_d%0d", s), 64'(rsp[s].data_gnt), 64'd0);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int g;
    int gc [4];
    int w;
    logic [55:0] a;

    rst = 1'b1;
    applyStimulus(0, 1'b1, 1'b1, 56'h100, 64'h1, 8'hFF, 1'b0, 1'b0);
    applyStimulus(1, 1'b1, 1'b1, 56'h100, 64'h1, 8'hFF, 1'b0, 1'b0);
    repeat (3) tick();
    rst = 1'b0;
    idle(0);
    idle(1);
    tick();

    $display("[TB] store then load");
    doStore(0, 56'h100, 64'hDEADBEEF_CAFEF00D, 8'hFF, g);
    doLoad(0, 56'h100, 1'b0, 0);
    repeat (3) tick();

    $display("[TB] partial write");
    doStore(0, 56'h40, 64'hFFFFFFFF_FFFFFFFF, 8'hFF, g);
    doStore(0, 56'h40, 64'h11223344_55667788, 8'h0F, g);
    idle(0);
    doLoad(0, 56'h40, 1'b0, 1);
    repeat (3) tick();

    $display("[TB] kill");
    doLoad(0, 56'h100, 1'b1, 0);
    repeat (10) tick();
    doStore(0, 56'h200, 64'h0123456789ABCDEF, 8'hFF, g);
    idle(0);
    tick();

    $display("[TB] grant delay");
    applyStimulus(1, 1'b1, 1'b1, 56'h300, 64'h5555AAAA_0000FFFF, 8'hFF, 1'b0, 1'b0);
    #1;
    checkOutput("drop_first_gnt", 64'(rsp[1].data_gnt), 64'd0);
    tick();
    idle(1);
    tick();
    doStore(1, 56'h300, 64'h5555AAAA_0000FFFF, 8'hFF, g);
    idle(1);
    doLoad(1, 56'h300, 1'b0, 0);
    repeat (4) tick();

    $display("[TB] back-to-back stores");
    for (int i = 0; i < 4; i++) begin
      doStore(0, 56'(i * 8), {$urandom, $urandom}, 8'hFF, gc[i]);
    end
    idle(0);
    for (int i = 1; i < 4; i++) begin
      checkOutput($sformatf("b2b_gnt_cycle_%0d", i), 64'(gc[i] - gc[0]), 64'(i));
    end
    for (int i = 0; i < 4; i++) doLoad(0, 56'(i * 8), 1'b0, 0);
    for (int i = 0; i < 4; i++) doStore(1, 56'(i * 8), {$urandom, $urandom}, 8'hFF, g);
    idle(1);
    for (int i = 0; i < 4; i++) doLoad(1, 56'(i * 8), 1'b0, i % 2);
    doLoad(0, 56'h8 + 56'(NW0 * 8 * 3), 1'b0, 0);
    doLoad(1, 56'h10 + 56'(NW1 * 8 * 5), 1'b0, 0);
    repeat (5) tick();

    $display("[TB] reset mid-load");
    doStore(1, 56'h500, 64'hA5A5A5A5_5A5A5A5A, 8'hFF, g);
    idle(1);
    doLoad(1, 56'h500, 1'b0, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    doLoad(1, 56'h500, 1'b0, 0);
    repeat (5) tick();

    $display("[TB] random traffic");
    for (int s = 0; s < 2; s++) begin
      for (int n = 0; n < 30; n++) begin
        w = $urandom_range(0, 31);
        a = mkAddr(s, w);
        if (!known.exists(mkey(s, a)) || $urandom_range(0, 2) == 0) begin
          doStore(s, a, {$urandom, $urandom}, known.exists(mkey(s, a)) ? 8'($urandom) : 8'hFF, g);
        end else begin
          doLoad(s, a, $urandom_range(0, 4) == 0, $urandom_range(0, 2));
        end
        if ($urandom_range(0, 1) == 1) begin
          idle(s);
          tick();
        end
      end
      idle(s);
      repeat (5) tick();
    end

    repeat (6) tick();
    checkOutput("pending_rvalid", 64'(expRv.num()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, errCount);
    $finish;
  end

endmodule
